sha256_msg_source: RTL and testbench

- Synthesizable, parametrised message-stream generator that drives the SHA256 core's load interface (load_enable / input_data / input_complete).
- Replaces the fixed 8-bit, 256-byte testbench counter sweep.
- Programmable data width, message length, pattern mode and seed, with ready-based backpressure.
- Sits between the test/config logic and the SHA256 input port; usable both on-chip as a BIST source and in simulation.

---
 rtl/sha256_msg_source.sv | 178 +++++++++++++++++
 tb/tb_sha256_msg_source.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_source.sv
// Parametrised message-stream generator for the SHA256 load interface.
// Emits msg_len beats of an increment/constant/LFSR/decrement pattern under ready backpressure.
module sha256_msg_source #(
    parameter int                DATA_W    = 8,
    parameter int                LEN_W     = 16,
    parameter logic [DATA_W-1:0] LFSR_POLY = 8'hB8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [LEN_W-1:0]  msg_len,
    input  logic              ready,
    output logic              load_enable,
    output logic [DATA_W-1:0] input_data,
    output logic              input_complete,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    function automatic logic [DATA_W-1:0] next_pattern(input logic [1:0] m,
                                                       input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        case (m)
            2'd0:    r = d + DATA_ONE;
            2'd1:    r = d;
            2'd2:    r = (d >> 1) ^ (d[0] ? LFSR_POLY : {DATA_W{1'b0}});
            2'd3:    r = d - DATA_ONE;
            default: r = d;
        endcase
        return r;
    endfunction

    // An all-zero LFSR state never leaves zero, so mode 2 starts from 1 instead.
    function automatic logic [DATA_W-1:0] seed_fix(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        if (m == 2'd2 && s == {DATA_W{1'b0}}) begin
            r = DATA_ONE;
        end else begin
            r = s;
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              le_q, le_d;
    logic              ic_q, ic_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic transfer_s;
    logic last_s;

    assign transfer_s = le_q & ready;
    assign last_s     = transfer_s & (cnt_q == (len_q - LEN_ONE));

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'd0;
            len_q   <= {LEN_W{1'b0}};
            cnt_q   <= {LEN_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            le_q    <= 1'b0;
            ic_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            le_q    <= le_d;
            ic_q    <= ic_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (msg_len == {LEN_W{1'b0}}) ? ST_COMPLETE : ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (last_s) begin
                    state_d = ST_COMPLETE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_COMPLETE: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Datapath and next values of the registered outputs.
    always_comb begin
        mode_d = mode_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        le_d   = le_q;
        ic_d   = 1'b0;
        busy_d = busy_q;
        done_d = done_q;
        case (state_q)
            ST_IDLE: begin
                le_d   = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    mode_d = mode;
                    len_d  = msg_len;
                    cnt_d  = {LEN_W{1'b0}};
                    data_d = seed_fix(mode, seed);
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    if (msg_len == {LEN_W{1'b0}}) begin
                        ic_d = 1'b1;
                    end else begin
                        le_d = 1'b1;
                    end
                end else begin
                    data_d = data_q;
                end
            end
            ST_LOAD: begin
                if (transfer_s) begin
                    cnt_d  = cnt_q + LEN_ONE;
                    data_d = next_pattern(mode_q, data_q);
                    le_d   = ~last_s;
                    ic_d   = last_s;
                end else begin
                    le_d = 1'b1;
                end
            end
            ST_COMPLETE: begin
                le_d   = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                le_d   = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign load_enable    = le_q;
    assign input_data     = data_q;
    assign input_complete = ic_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_sha256_msg_source.sv
// Self-checking bench for sha256_msg_source: directed table, abort-by-reset and randomized messages
// compared against an arithmetic reference of the expected beat stream.
module tb_sha256_msg_source;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  seed;
    logic [15:0] msg_len;
    logic        ready;
    logic        load_enable;
    logic [7:0]  input_data;
    logic        input_complete;
    logic        busy;
    logic        done;

    int nvec = 0;
    int nerr = 0;

    sha256_msg_source #(.DATA_W(8), .LEN_W(16), .LFSR_POLY(8'hB8)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .seed           (seed),
        .msg_len        (msg_len),
        .ready          (ready),
        .load_enable    (load_enable),
        .input_data     (input_data),
        .input_complete (input_complete),
        .busy           (busy),
        .done           (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] m;
        logic [7:0] s;
        int         len;
        int         rpat;
        bit         poke;
        logic [7:0] first;
        logic [7:0] last;
    } vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Beat i of a message: plain modular arithmetic, or i LFSR steps from the (fixed) seed.
    function automatic logic [7:0] model_beat(input logic [1:0] m, input logic [7:0] s, input int i);
        logic [7:0] d;
        case (m)
            2'd0: return s + 8'(i);
            2'd1: return s;
            2'd3: return s - 8'(i);
            default: begin
                d = (s == 8'h00) ? 8'h01 : s;
                for (int k = 0; k < i; k++) d = (d >> 1) ^ (d[0] ? 8'hB8 : 8'h00);
                return d;
            end
        endcase
    endfunction

    function automatic logic pick_ready(input int rpat, input int k);
        if (rpat == 0) return 1'b1;
        if (rpat == 2) return (k % 3) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic run_msg(input logic [1:0] m, input logic [7:0] s, input int len, input int rpat,
                           input bit poke, input bit chk_ends, input logic [7:0] exp_first,
                           input logic [7:0] exp_last);
        logic [7:0] got[$];
        logic [7:0] held;
        int         k, last_edge, ic_edge, le_seen;
        bit         ic_seen, stalled;
        got = {};
        held = 8'h00;
        k = 0; last_edge = 0; ic_edge = -1; le_seen = 0; ic_seen = 1'b0; stalled = 1'b0;
        mode = m; seed = s; msg_len = 16'(len); start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_cleared", 32'(done), 32'd0);
        while (!ic_seen && k < len * 4 + 40) begin
            if (stalled) begin
                check("stall_hold_le", 32'(load_enable), 32'd1);
                check("stall_hold_data", 32'(input_data), 32'(held));
            end
            if (input_complete) begin
                ic_seen = 1'b1;
                ic_edge = k;
                check("le_low_at_complete", 32'(load_enable), 32'd0);
                check("busy_at_complete", 32'(busy), 32'd1);
            end else begin
                if (load_enable) le_seen++;
                ready = pick_ready(rpat, k);
                stalled = load_enable && !ready;
                held = input_data;
                if (load_enable && ready) begin
                    got.push_back(input_data);
                    last_edge = k + 1;
                end
                if (poke && busy) begin
                    start = 1'(($urandom_range(0, 1)));
                    mode = 2'($urandom);
                    seed = 8'($urandom);
                    msg_len = 16'($urandom_range(0, 9));
                end else begin
                    start = 1'b0;
                end
                tick();
                k++;
            end
        end
        start = 1'b0;
        check("complete_seen", 32'(ic_seen), 32'd1);
        check("complete_after_last_beat", 32'(ic_edge), 32'(last_edge));
        if (rpat == 0) check("complete_latency", 32'(ic_edge), 32'(len));
        tick();
        check("complete_one_cycle", 32'(input_complete), 32'd0);
        check("busy_low_after", 32'(busy), 32'd0);
        check("done_set", 32'(done), 32'd1);
        check("le_low_after", 32'(load_enable), 32'd0);
        check("beat_count", 32'(got.size()), 32'(len));
        if (len == 0) check("no_load_enable", 32'(le_seen), 32'd0);
        for (int i = 0; i < got.size() && i < len; i++) begin
            check("beat_value", 32'(got[i]), 32'(model_beat(m, s, i)));
        end
        if (chk_ends && len > 0 && got.size() == len) begin
            check("first_beat", 32'(got[0]), 32'(exp_first));
            check("last_beat", 32'(got[len-1]), 32'(exp_last));
        end
    endtask

    initial begin
        vec_t tbl[7];
        int   n, guard;
        tbl[0] = '{2'd0, 8'h00, 3,   0, 1'b0, 8'h00, 8'h02};
        tbl[1] = '{2'd0, 8'h00, 256, 0, 1'b0, 8'h00, 8'hFF};
        tbl[2] = '{2'd0, 8'hFE, 4,   2, 1'b0, 8'hFE, 8'h01};
        tbl[3] = '{2'd2, 8'h00, 6,   0, 1'b0, 8'h01, 8'hB3};
        tbl[4] = '{2'd1, 8'h00, 0,   0, 1'b0, 8'h00, 8'h00};
        tbl[5] = '{2'd3, 8'h02, 4,   0, 1'b1, 8'h02, 8'hFF};
        tbl[6] = '{2'd1, 8'h5A, 5,   1, 1'b0, 8'h5A, 8'h5A};

        reset = 1'b0; start = 1'b0; mode = 2'd0; seed = 8'h00; msg_len = 16'd0; ready = 1'b0;
        #2;
        check("rst_le", 32'(load_enable), 32'd0);
        check("rst_data", 32'(input_data), 32'd0);
        check("rst_ic", 32'(input_complete), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        #20 reset = 1'b1;
        tick();

        for (int t = 0; t < 7; t++) begin
            run_msg(tbl[t].m, tbl[t].s, tbl[t].len, tbl[t].rpat, tbl[t].poke, 1'b1,
                    tbl[t].first, tbl[t].last);
            tick();
        end

        // Abort: reset in the middle of a 10-beat message after 5 beats.
        mode = 2'd0; seed = 8'h10; msg_len = 16'd10; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        n = 0; guard = 0;
        while (n < 5 && guard < 50) begin
            if (load_enable && ready) n++;
            if (n < 5) tick();
            guard++;
        end
        check("abort_reach_beat5", 32'(n), 32'd5);
        #3 reset = 1'b0;
        #1;
        check("abort_le", 32'(load_enable), 32'd0);
        check("abort_data", 32'(input_data), 32'd0);
        check("abort_ic", 32'(input_complete), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (3) begin
            tick();
            check("abort_no_complete", 32'(input_complete), 32'd0);
        end
        #3 reset = 1'b1;
        tick();
        check("abort_idle_no_complete", 32'(input_complete), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);
        run_msg(2'd0, 8'h10, 10, 0, 1'b0, 1'b1, 8'h10, 8'h19);
        tick();

        for (int r = 0; r < 20; r++) begin
            run_msg(2'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 40)), 1,
                    1'($urandom_range(0, 1)), 1'b0, 8'h00, 8'h00);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
